// File: rtl/ltl_nfa_monitor_if.sv
// Bus bundle for ltl_nfa_monitor: symbol stream, configuration write port and monitor results.
interface ltl_nfa_monitor_if #(
    parameter int unsigned NUM_STATES = 16,
    parameter int unsigned SYM_W      = 8,
    parameter int unsigned NUM_RANGES = 4,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned ST_W  = $clog2(NUM_STATES);
    localparam int unsigned FLD_W = $clog2(2 * NUM_RANGES + 3);

    logic                  run;
    logic                  clear;
    logic                  sym_valid;
    logic [SYM_W-1:0]      symbols;
    logic                  cfg_we;
    logic [ST_W-1:0]       cfg_state;
    logic [FLD_W-1:0]      cfg_field;
    logic [31:0]           cfg_wdata;
    logic                  cfg_err;
    logic [NUM_STATES-1:0] report;
    logic                  violation;
    logic [CNT_W-1:0]      report_cnt;
    logic [CNT_W-1:0]      first_idx;
    logic                  first_vld;

    modport master (
        output run, clear, sym_valid, symbols, cfg_we, cfg_state, cfg_field, cfg_wdata,
        input  cfg_err, report, violation, report_cnt, first_idx, first_vld
    );

    modport slave (
        input  run, clear, sym_valid, symbols, cfg_we, cfg_state, cfg_field, cfg_wdata,
        output cfg_err, report, violation, report_cnt, first_idx, first_vld
    );
endinterface

// File: rtl/ltl_nfa_monitor.sv
// Homogeneous-NFA runtime monitor: STEs with interval symbol classes, an edge matrix and
// start-of-data / all-input starts; reports, sticky violation and first-report capture.
module ltl_nfa_monitor #(
    parameter int unsigned NUM_STATES = 16,
    parameter int unsigned SYM_W      = 8,
    parameter int unsigned NUM_RANGES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    ltl_nfa_monitor_if.slave bus
);
    localparam int unsigned ST_W       = $clog2(NUM_STATES);
    localparam int unsigned FLD_W      = $clog2(2 * NUM_RANGES + 3);
    localparam int unsigned NUM_FIELDS = 2 * NUM_RANGES + 3;
    localparam int unsigned F_EN       = 2 * NUM_RANGES;
    localparam int unsigned F_PRED     = 2 * NUM_RANGES + 1;
    localparam int unsigned F_MODE     = 2 * NUM_RANGES + 2;
    localparam logic [1:0]  START_SOD  = 2'd1;
    localparam logic [1:0]  START_ALL  = 2'd2;

    // Configuration storage
    logic [NUM_STATES-1:0][NUM_RANGES-1:0][SYM_W-1:0] lo_q, lo_d;
    logic [NUM_STATES-1:0][NUM_RANGES-1:0][SYM_W-1:0] hi_q, hi_d;
    logic [NUM_STATES-1:0][NUM_RANGES-1:0]            en_q, en_d;
    logic [NUM_STATES-1:0][NUM_STATES-1:0]            pred_q, pred_d;
    logic [NUM_STATES-1:0]                            rep_q, rep_d;
    logic [NUM_STATES-1:0][1:0]                       stype_q, stype_d;
    logic                                             cfg_err_q, cfg_err_d;
    logic                                             field_ok_c;
    logic                                             cfg_wr_c;

    // Matching state
    logic [NUM_STATES-1:0] act_q, act_d;
    logic [NUM_STATES-1:0] report_q, report_d;
    logic [NUM_STATES-1:0] match_c;
    logic [NUM_STATES-1:0] act_nxt_c;
    logic [CNT_W-1:0]      sym_idx_q, sym_idx_d;
    logic [CNT_W-1:0]      report_cnt_q, report_cnt_d;
    logic [CNT_W-1:0]      first_idx_q, first_idx_d;
    logic                  first_vld_q, first_vld_d;
    logic                  violation_q, violation_d;
    logic                  sod_q, sod_d;
    logic                  accept_c;

    // Only the low bits of the write word are meaningful for any field
    wire unused_wdata = &{1'b0, bus.cfg_wdata};

    // Configuration write decode; rejected writes only raise cfg_err
    always_comb begin : cfg_next
        lo_d       = lo_q;
        hi_d       = hi_q;
        en_d       = en_q;
        pred_d     = pred_q;
        rep_d      = rep_q;
        stype_d    = stype_q;
        field_ok_c = (32'(bus.cfg_field) < NUM_FIELDS);
        cfg_err_d  = bus.cfg_we && (bus.run || !field_ok_c);
        cfg_wr_c   = bus.cfg_we && !bus.run && field_ok_c;
        for (int unsigned s = 0; s < NUM_STATES; s++) begin
            if (cfg_wr_c && (bus.cfg_state == ST_W'(s))) begin
                for (int unsigned r = 0; r < NUM_RANGES; r++) begin
                    if (bus.cfg_field == FLD_W'(2 * r))
                        lo_d[s][r] = bus.cfg_wdata[SYM_W-1:0];
                    if (bus.cfg_field == FLD_W'(2 * r + 1))
                        hi_d[s][r] = bus.cfg_wdata[SYM_W-1:0];
                end
                if (bus.cfg_field == FLD_W'(F_EN))
                    en_d[s] = bus.cfg_wdata[NUM_RANGES-1:0];
                if (bus.cfg_field == FLD_W'(F_PRED))
                    pred_d[s] = bus.cfg_wdata[NUM_STATES-1:0];
                if (bus.cfg_field == FLD_W'(F_MODE)) begin
                    rep_d[s]   = bus.cfg_wdata[2];
                    stype_d[s] = bus.cfg_wdata[1:0];
                end
            end
        end
    end

    // Symbol classification and NFA transition
    always_comb begin : match_eval
        match_c   = '0;
        act_nxt_c = '0;
        for (int unsigned s = 0; s < NUM_STATES; s++) begin
            for (int unsigned r = 0; r < NUM_RANGES; r++) begin
                if (en_q[s][r] && (bus.symbols >= lo_q[s][r]) && (bus.symbols <= hi_q[s][r]))
                    match_c[s] = 1'b1;
            end
            act_nxt_c[s] = match_c[s] &&
                           ((|(act_q & pred_q[s])) ||
                            (stype_q[s] == START_ALL) ||
                            ((stype_q[s] == START_SOD) && sod_q));
        end
    end

    // Clear has priority over an accepted symbol; otherwise everything holds
    always_comb begin : run_next
        act_d        = act_q;
        report_d     = '0;
        sym_idx_d    = sym_idx_q;
        report_cnt_d = report_cnt_q;
        first_idx_d  = first_idx_q;
        first_vld_d  = first_vld_q;
        violation_d  = violation_q;
        sod_d        = sod_q;
        accept_c     = bus.run && bus.sym_valid && !bus.clear;
        if (bus.clear) begin
            act_d        = '0;
            sym_idx_d    = '0;
            report_cnt_d = '0;
            first_idx_d  = '0;
            first_vld_d  = 1'b0;
            violation_d  = 1'b0;
            sod_d        = 1'b1;
        end else if (accept_c) begin
            act_d     = act_nxt_c;
            report_d  = act_nxt_c & rep_q;
            sym_idx_d = sym_idx_q + CNT_W'(1);
            sod_d     = 1'b0;
            if (|report_d) begin
                violation_d = 1'b1;
                if (report_cnt_q != '1)
                    report_cnt_d = report_cnt_q + CNT_W'(1);
                if (!first_vld_q) begin
                    first_idx_d = sym_idx_q;
                    first_vld_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : cfg_regs
        if (!reset_n) begin
            lo_q      <= '0;
            hi_q      <= '0;
            en_q      <= '0;
            pred_q    <= '0;
            rep_q     <= '0;
            stype_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            en_q      <= en_d;
            pred_q    <= pred_d;
            rep_q     <= rep_d;
            stype_q   <= stype_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : run_regs
        if (!reset_n) begin
            act_q        <= '0;
            report_q     <= '0;
            sym_idx_q    <= '0;
            report_cnt_q <= '0;
            first_idx_q  <= '0;
            first_vld_q  <= 1'b0;
            violation_q  <= 1'b0;
            sod_q        <= 1'b1;
        end else begin
            act_q        <= act_d;
            report_q     <= report_d;
            sym_idx_q    <= sym_idx_d;
            report_cnt_q <= report_cnt_d;
            first_idx_q  <= first_idx_d;
            first_vld_q  <= first_vld_d;
            violation_q  <= violation_d;
            sod_q        <= sod_d;
        end
    end

    assign bus.cfg_err    = cfg_err_q;
    assign bus.report     = report_q;
    assign bus.violation  = violation_q;
    assign bus.report_cnt = report_cnt_q;
    assign bus.first_idx  = first_idx_q;
    assign bus.first_vld  = first_vld_q;
endmodule

// File: tb/tb_ltl_nfa_monitor.sv
// Directed bench for ltl_nfa_monitor with an abstract NFA model checked every cycle.
module tb_ltl_nfa_monitor;
    localparam int unsigned NS     = 4;
    localparam int unsigned SW     = 8;
    localparam int unsigned NR     = 2;
    localparam int unsigned CW     = 8;
    localparam int unsigned TST_W  = $clog2(NS);
    localparam int unsigned TFLD_W = $clog2(2 * NR + 3);
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ltl_nfa_monitor_if #(.NUM_STATES(NS), .SYM_W(SW), .NUM_RANGES(NR), .CNT_W(CW)) bus ();

    ltl_nfa_monitor #(.NUM_STATES(NS), .SYM_W(SW), .NUM_RANGES(NR), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: configuration as plain tables, active set as a bit per STE, counts as integers
    int          m_lo    [NS][NR];
    int          m_hi    [NS][NR];
    bit          m_en    [NS][NR];
    bit          m_edge  [NS][NS];
    bit          m_rep   [NS];
    int          m_start [NS];
    bit          m_act   [NS];
    bit          m_sod;
    int          m_nsym;
    int          m_nrep;
    int          m_first;
    bit          m_viol;
    bit          m_err;
    logic [NS-1:0] m_report;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NS; i++) m_act[i] = 1'b0;
        m_sod    = 1'b1;
        m_nsym   = 0;
        m_nrep   = 0;
        m_first  = -1;
        m_viol   = 1'b0;
        m_report = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            for (int r = 0; r < NR; r++) begin
                m_lo[i][r] = 0;
                m_hi[i][r] = 0;
                m_en[i][r] = 1'b0;
            end
            for (int j = 0; j < NS; j++) m_edge[i][j] = 1'b0;
            m_rep[i]   = 1'b0;
            m_start[i] = 0;
        end
        model_clear();
        m_err = 1'b0;
    endtask

    task automatic model_step();
        int f;
        int st;
        int s;
        logic [31:0] d;
        logic [NS-1:0] nxt;
        bit hit;
        bit enter;
        if (!rst_n) begin
            model_reset();
            return;
        end
        f  = int'(bus.cfg_field);
        st = int'(bus.cfg_state);
        d  = bus.cfg_wdata;
        m_err = bus.cfg_we && (bus.run || f > 2 * NR + 2);
        if (bus.cfg_we && !bus.run && f <= 2 * NR + 2) begin
            if (f < 2 * NR) begin
                if (f % 2 == 0) m_lo[st][f / 2] = int'(d[SW-1:0]);
                else            m_hi[st][f / 2] = int'(d[SW-1:0]);
            end else if (f == 2 * NR) begin
                for (int r = 0; r < NR; r++) m_en[st][r] = d[r];
            end else if (f == 2 * NR + 1) begin
                for (int j = 0; j < NS; j++) m_edge[st][j] = d[j];
            end else begin
                m_rep[st]   = d[2];
                m_start[st] = int'(d[1:0]);
            end
        end
        if (bus.clear) begin
            model_clear();
        end else if (bus.run && bus.sym_valid) begin
            s = int'(bus.symbols);
            nxt = '0;
            for (int i = 0; i < NS; i++) begin
                hit = 1'b0;
                for (int r = 0; r < NR; r++)
                    if (m_en[i][r] && m_lo[i][r] <= s && s <= m_hi[i][r]) hit = 1'b1;
                enter = (m_start[i] == 2) || (m_start[i] == 1 && m_sod);
                for (int j = 0; j < NS; j++)
                    if (m_act[j] && m_edge[i][j]) enter = 1'b1;
                nxt[i] = hit && enter;
            end
            m_report = '0;
            for (int i = 0; i < NS; i++) begin
                m_act[i] = nxt[i];
                if (nxt[i] && m_rep[i]) m_report[i] = 1'b1;
            end
            if (m_report != '0) begin
                m_nrep++;
                m_viol = 1'b1;
                if (m_first < 0) m_first = m_nsym % (1 << CW);
            end
            m_nsym++;
            m_sod = 1'b0;
        end else begin
            m_report = '0;
        end
    endtask

    task automatic check_all();
        chk("report",     32'(bus.report),     32'(m_report));
        chk("violation",  32'(bus.violation),  32'(m_viol));
        chk("report_cnt", 32'(bus.report_cnt), 32'((m_nrep > CNT_MAX) ? CNT_MAX : m_nrep));
        chk("first_idx",  32'(bus.first_idx),  32'((m_first < 0) ? 0 : m_first));
        chk("first_vld",  32'(bus.first_vld),  32'(m_first >= 0));
        chk("cfg_err",    32'(bus.cfg_err),    32'(m_err));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic cfg(input int s, input int f, input int d);
        bus.cfg_we    = 1'b1;
        bus.cfg_state = TST_W'(s);
        bus.cfg_field = TFLD_W'(f);
        bus.cfg_wdata = 32'(d);
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic sym(input int v);
        bus.sym_valid = 1'b1;
        bus.symbols   = SW'(v);
        tick();
        bus.sym_valid = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        bus.run = 1'b0; bus.clear = 1'b0; bus.sym_valid = 1'b0; bus.symbols = '0;
        bus.cfg_we = 1'b0; bus.cfg_state = '0; bus.cfg_field = '0; bus.cfg_wdata = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_report",     32'(bus.report),     32'd0);
        chk("rst_violation",  32'(bus.violation),  32'd0);
        chk("rst_report_cnt", 32'(bus.report_cnt), 32'd0);
        chk("rst_first_vld",  32'(bus.first_vld),  32'd0);
        chk("rst_cfg_err",    32'(bus.cfg_err),    32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // STE0 sod [0,31] report; STE1 all-input [64,95] pred STE0 report; STE2 sod [128,159] + empty range
        cfg(0, 0, 0);   cfg(0, 1, 31);  cfg(0, 4, 1);   cfg(0, 6, 5);
        cfg(1, 0, 64);  cfg(1, 1, 95);  cfg(1, 4, 1);   cfg(1, 5, 1);  cfg(1, 6, 6);
        cfg(2, 0, 128); cfg(2, 1, 159); cfg(2, 2, 200); cfg(2, 3, 100); cfg(2, 4, 3); cfg(2, 6, 5);

        // Basic chain: 5,70,70
        bus.run = 1'b1;
        sym(5);   chk("a_rep0", 32'(bus.report), 32'h1);
        sym(70);  chk("a_rep1", 32'(bus.report), 32'h2);
        sym(70);  chk("a_rep2", 32'(bus.report), 32'h2);
        tick();   chk("a_idle", 32'(bus.report), 32'h0);
        chk("a_first_idx", 32'(bus.first_idx),  32'd0);
        chk("a_first_vld", 32'(bus.first_vld),  32'd1);
        chk("a_cnt",       32'(bus.report_cnt), 32'd3);
        chk("a_viol",      32'(bus.violation),  32'd1);

        // Missed start-of-data, then re-armed by clear; lo>hi range never matches 200
        do_clear();
        sym(200); chk("b_rep200", 32'(bus.report), 32'h0);
        sym(130); chk("b_rep130", 32'(bus.report), 32'h0);
        chk("b_viol", 32'(bus.violation), 32'd0);
        do_clear();
        sym(130); chk("b_rep_sod", 32'(bus.report), 32'h4);

        // Clear together with a matching symbol
        bus.clear = 1'b1; bus.sym_valid = 1'b1; bus.symbols = SW'(5);
        tick();
        bus.clear = 1'b0; bus.sym_valid = 1'b0;
        chk("c_rep",  32'(bus.report),    32'h0);
        chk("c_viol", 32'(bus.violation), 32'd0);
        chk("c_fvld", 32'(bus.first_vld), 32'd0);
        sym(5);   chk("c_rep_after", 32'(bus.report), 32'h1);

        // Rejected writes: while running, and to a field beyond the map
        cfg(0, 4, 0); chk("d_err_run", 32'(bus.cfg_err), 32'd1);
        tick();       chk("d_err_gone", 32'(bus.cfg_err), 32'd0);
        do_clear();
        sym(5);       chk("d_cfg_kept", 32'(bus.report), 32'h1);
        bus.run = 1'b0;
        cfg(0, 7, 0); chk("d_err_field", 32'(bus.cfg_err), 32'd1);

        // Range edges, run freeze without sod re-arm
        bus.run = 1'b1;
        do_clear();
        sym(31);  chk("e_rep31", 32'(bus.report), 32'h1);
        bus.run = 1'b0; bus.sym_valid = 1'b1; bus.symbols = SW'(70);
        tick(); tick();
        chk("e_frozen", 32'(bus.report), 32'h0);
        bus.sym_valid = 1'b0; bus.run = 1'b1;
        sym(5);   chk("e_no_rearm", 32'(bus.report), 32'h0);
        sym(70);  chk("e_resume",   32'(bus.report), 32'h2);
        do_clear();
        sym(32);  chk("e_rep32", 32'(bus.report), 32'h0);

        // Self-loop STE3 over the full symbol range; counter saturation and index wrap
        bus.run = 1'b0;
        cfg(3, 0, 0); cfg(3, 1, 255); cfg(3, 4, 1); cfg(3, 5, 8); cfg(3, 6, 5);
        bus.run = 1'b1;
        do_clear();
        for (int k = 0; k < (1 << CW) + 5; k++) sym(200);
        chk("f_rep",       32'(bus.report),     32'h8);
        chk("f_cnt_sat",   32'(bus.report_cnt), 32'd255);
        chk("f_first_idx", 32'(bus.first_idx),  32'd0);
        chk("f_first_vld", 32'(bus.first_vld),  32'd1);

        // Asynchronous reset between edges while reporting
        sym(200); chk("g_pre_rep", 32'(bus.report), 32'h8);
        bus.sym_valid = 1'b1; bus.symbols = SW'(200);
        #2 rst_n = 1'b0;
        #1;
        chk("g_rep_async",  32'(bus.report),     32'h0);
        chk("g_viol_async", 32'(bus.violation),  32'd0);
        chk("g_cnt_async",  32'(bus.report_cnt), 32'd0);
        chk("g_fvld_async", 32'(bus.first_vld),  32'd0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        bus.sym_valid = 1'b0;
        sym(5);   chk("g_rep5",   32'(bus.report), 32'h0);
        sym(70);  chk("g_rep70",  32'(bus.report), 32'h0);
        sym(130); chk("g_rep130", 32'(bus.report), 32'h0);
        sym(200); chk("g_rep200", 32'(bus.report), 32'h0);
        chk("g_viol", 32'(bus.violation), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
